// File: rtl/ring_pkg.sv
// ring_pkg: shared packet-field helpers and arbiter state encoding for the
// ring transmit path.
package ring_pkg;

  // Default ring packet geometry.
  localparam int RING_WIDTH = 16;
  localparam int RING_ABITS = 3;

  // Control bits sit at the top of every packet.
  localparam int FULL_BIT = RING_WIDTH - 1;
  localparam int ACK_BIT  = RING_WIDTH - 2;

  // FULL flag position for an arbitrary packet width.
  function automatic int full_bit(input int width);
    return width - 1;
  endfunction

  // ACK flag position for an arbitrary packet width.
  function automatic int ack_bit(input int width);
    return width - 2;
  endfunction

  // DST field sits directly below ACK.
  function automatic int dst_lsb(input int width, input int abits);
    return width - 2 - abits;
  endfunction

  // SRC field sits directly below DST.
  function automatic int src_lsb(input int width, input int abits);
    return width - 2 - 2 * abits;
  endfunction

  // Transmit arbiter states.
  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    WAIT_ACK   = 2'd1,
    WAIT_DRAIN = 2'd2
  } arb_state_e;

endpackage

// File: rtl/ring_tx_arbiter_rr_pick.sv
// rr_pick: combinational round-robin selector. Searches i_req starting one
// past i_last with wrap-around and returns the first requester found as a
// one-hot vector, an index and an any-request flag.
module rr_pick #(
  parameter  int NREQ = 4,
  localparam int LW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] i_req,
  input  logic [LW-1:0]   i_last,
  output logic [NREQ-1:0] o_onehot,
  output logic [LW-1:0]   o_idx,
  output logic            o_any
);

  logic [LW:0]     w_shamt;
  logic [NREQ-1:0] w_rot;
  logic [LW-1:0]   w_off;
  logic [LW:0]     w_sum;

  // Rotate so bit 0 of w_rot is the requester right after i_last.
  assign w_shamt = {1'b0, i_last} + (LW+1)'(1);
  assign w_rot   = NREQ'({i_req, i_req} >> w_shamt);

  // Lowest set bit of the rotated vector wins; map it back to an index.
  always_comb begin
    w_off = '0;
    o_any = 1'b0;
    for (int j = NREQ - 1; j >= 0; j--) begin
      if (w_rot[j]) begin
        o_any = 1'b1;
        w_off = LW'(j);
      end
    end
    w_sum = {1'b0, i_last} + {1'b0, w_off} + (LW+1)'(1);
    if (w_sum >= (LW+1)'(NREQ)) begin
      w_sum = w_sum - (LW+1)'(NREQ);
    end
    o_idx    = w_sum[LW-1:0];
    o_onehot = o_any ? (NREQ'(1) << o_idx) : '0;
  end

endmodule

// File: rtl/ring_tx_arbiter.sv
// ring_tx_arbiter: round-robin sharing of one ring node client transmit port
// between NREQ local requesters, using the node's toggle valid/ack handshake
// and waiting for the node transmit buffer to drain between grants.
// Optional macro RING_ARB_GRANT_COUNT_EN adds per-requester saturating grant
// counters (gntcount) with a synchronous clear input (cntclr).
module ring_tx_arbiter
  import ring_pkg::*;
#(
  parameter  int NREQ  = 4,
  parameter  int WIDTH = 16,
  parameter  int ABITS = 3,
  localparam int LW    = $clog2(NREQ)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*WIDTH-1:0] reqdata,
  output logic [NREQ-1:0]       gnt,
  output logic [WIDTH-1:0]      pktdata,
  output logic                  pktvalid,
  input  logic                  pktack,
  input  logic                  txready,
  output logic                  busy,
  output logic [LW-1:0]         last
`ifdef RING_ARB_GRANT_COUNT_EN
  ,
  input  logic                  cntclr,
  output logic [NREQ*8-1:0]     gntcount
`endif
);

  localparam int FULL_IDX = full_bit(WIDTH);
  localparam int DST_LSB  = dst_lsb(WIDTH, ABITS);

  // A DST field that would reach below bit 1 leaves no room for SRC; such a
  // configuration elaborates this marker block so it shows up in the netlist.
  if (DST_LSB < 1) begin : g_dst_field_too_wide
  end

  arb_state_e       r_state;
  arb_state_e       w_state_next;
  logic             w_take;
  logic [NREQ-1:0]  r_gnt;
  logic [WIDTH-1:0] r_pktdata;
  logic             r_pktvalid;
  logic [LW-1:0]    r_last;
  logic [NREQ-1:0]  w_pick_onehot;
  logic [LW-1:0]    w_pick_idx;
  logic             w_pick_any;
  logic [WIDTH-1:0] w_req_pkt [NREQ];
  logic [WIDTH-1:0] w_pkt;

  // Split the flat request bus into one packet per requester.
  for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
    assign w_req_pkt[gi] = reqdata[gi*WIDTH +: WIDTH];
  end

  rr_pick #(.NREQ(NREQ)) u_pick (
    .i_req    (req),
    .i_last   (r_last),
    .o_onehot (w_pick_onehot),
    .o_idx    (w_pick_idx),
    .o_any    (w_pick_any)
  );

  // Winner's packet with FULL forced; the node fills in SRC itself.
  always_comb begin
    w_pkt           = w_req_pkt[w_pick_idx];
    w_pkt[FULL_IDX] = 1'b1;
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next state and the one-cycle capture strobe.
  always_comb begin
    w_state_next = r_state;
    w_take       = 1'b0;
    case (r_state)
      IDLE: begin
        if (txready && (pktack == r_pktvalid) && w_pick_any) begin
          w_take       = 1'b1;
          w_state_next = WAIT_ACK;
        end
      end
      WAIT_ACK: begin
        if (pktack == r_pktvalid) begin
          w_state_next = WAIT_DRAIN;
        end
      end
      WAIT_DRAIN: begin
        if (txready) begin
          w_state_next = IDLE;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  // Capture packet, toggle valid and pulse the grant on selection.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_gnt      <= '0;
      r_pktdata  <= '0;
      r_pktvalid <= 1'b0;
      r_last     <= LW'(NREQ - 1);
    end else begin
      r_gnt <= '0;
      if (w_take) begin
        r_gnt      <= w_pick_onehot;
        r_pktdata  <= w_pkt;
        r_pktvalid <= ~r_pktvalid;
        r_last     <= w_pick_idx;
      end
    end
  end

  assign gnt      = r_gnt;
  assign pktdata  = r_pktdata;
  assign pktvalid = r_pktvalid;
  assign last     = r_last;
  assign busy     = (r_state != IDLE);

`ifdef RING_ARB_GRANT_COUNT_EN
  for (genvar gi = 0; gi < NREQ; gi++) begin : g_cnt
    logic [7:0] r_cnt;

    // Saturating count of this requester's grant pulses; clear wins.
    always_ff @(posedge clk) begin
      if (rst || cntclr) begin
        r_cnt <= '0;
      end else if (r_gnt[gi] && (r_cnt != 8'hFF)) begin
        r_cnt <= r_cnt + 8'd1;
      end
    end

    assign gntcount[gi*8 +: 8] = r_cnt;
  end
`endif

endmodule

// File: tb/tb_ring_tx_arbiter.sv
// tb_ring_tx_arbiter: randomized and directed bench for ring_tx_arbiter with a
// transaction-level reference model and a ring node model driving pktack and
// txready. Optional macro RING_ARB_GRANT_COUNT_EN enables counter checks.
module tb_ring_tx_arbiter;

  localparam int NREQ  = 4;
  localparam int WIDTH = 16;
  localparam int LW    = $clog2(NREQ);

  logic                  clk = 1'b0;
  logic                  rst = 1'b1;
  logic [NREQ-1:0]       req = '0;
  logic [NREQ*WIDTH-1:0] reqdata = '0;
  logic                  pktack = 1'b0;
  logic                  txready = 1'b1;
  logic [NREQ-1:0]       gnt;
  logic [WIDTH-1:0]      pktdata;
  logic                  pktvalid;
  logic                  busy;
  logic [LW-1:0]         last;
`ifdef RING_ARB_GRANT_COUNT_EN
  logic                  cntclr = 1'b0;
  logic [NREQ*8-1:0]     gntcount;
`endif

  always #5 clk = ~clk;

  ring_tx_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH), .ABITS(3)) dut (
    .clk      (clk),
    .rst      (rst),
    .req      (req),
    .reqdata  (reqdata),
    .gnt      (gnt),
    .pktdata  (pktdata),
    .pktvalid (pktvalid),
    .pktack   (pktack),
    .txready  (txready),
    .busy     (busy),
    .last     (last)
`ifdef RING_ARB_GRANT_COUNT_EN
    ,
    .cntclr   (cntclr),
    .gntcount (gntcount)
`endif
  );

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: dut=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic timeout(input string name);
    n_cmp++;
    n_fail++;
    $display("FAIL %s: timed out at %0t", name, $time);
  endtask

  // ---------------- reference model (transaction level) ----------------
  // A packet is "outstanding" from capture until the node acks it, then the
  // arbiter is "draining" until the node buffer reports empty.
  bit               m_known = 1'b0;
  bit               m_outstanding, m_draining;
  bit               m_valid;
  logic [WIDTH-1:0] m_data;
  logic [NREQ-1:0]  m_gnt;
  int               m_last;
`ifdef RING_ARB_GRANT_COUNT_EN
  int               m_cnt [NREQ];
`endif

  always @(posedge clk) begin
    int win;
    int k;
    if (rst) begin
      m_known = 1'b1; m_outstanding = 1'b0; m_draining = 1'b0;
      m_valid = 1'b0; m_data = '0; m_gnt = '0; m_last = NREQ - 1;
`ifdef RING_ARB_GRANT_COUNT_EN
      for (int i = 0; i < NREQ; i++) m_cnt[i] = 0;
`endif
    end else begin
`ifdef RING_ARB_GRANT_COUNT_EN
      for (int i = 0; i < NREQ; i++) begin
        if (cntclr) m_cnt[i] = 0;
        else if (m_gnt[i] && m_cnt[i] < 255) m_cnt[i] = m_cnt[i] + 1;
      end
`endif
      m_gnt = '0;
      if (m_outstanding) begin
        if (pktack == m_valid) begin
          m_outstanding = 1'b0;
          m_draining = 1'b1;
        end
      end else if (m_draining) begin
        if (txready) m_draining = 1'b0;
      end else if (txready && pktack == m_valid && req != '0) begin
        win = -1;
        for (int off = 1; off <= NREQ; off++) begin
          k = (m_last + off) % NREQ;
          if (win < 0 && req[k]) win = k;
        end
        m_gnt[win]    = 1'b1;
        m_data        = reqdata[win*WIDTH +: WIDTH] | 16'h8000;
        m_valid       = ~m_valid;
        m_last        = win;
        m_outstanding = 1'b1;
      end
    end
  end

  // ---------------- per-cycle compare and bookkeeping ----------------
  int glog [$];
  int n_toggle = 0, n_gntpulse = 0;
  bit prev_valid = 1'b0;
  bit gnt3_seen = 1'b0;
  int wait_cnt [NREQ];

  always @(negedge clk) begin
    int win;
    if (m_known) begin
      check("gnt", 64'(gnt), 64'(m_gnt));
      check("pktdata", 64'(pktdata), 64'(m_data));
      check("pktvalid", 64'(pktvalid), 64'(m_valid));
      check("busy", 64'(busy), 64'(m_outstanding || m_draining));
      check("last", 64'(last), 64'(m_last));
`ifdef RING_ARB_GRANT_COUNT_EN
      for (int i = 0; i < NREQ; i++) check("gntcount", 64'(gntcount[i*8 +: 8]), 64'(m_cnt[i]));
`endif
      if (rst) begin
        n_toggle = 0; n_gntpulse = 0;
        for (int i = 0; i < NREQ; i++) wait_cnt[i] = 0;
      end else begin
        if (pktvalid !== prev_valid) n_toggle++;
        if (gnt != '0) begin
          n_gntpulse++;
          win = 0;
          for (int i = 0; i < NREQ; i++) if (gnt[i]) win = i;
          if (gnt[3]) gnt3_seen = 1'b1;
          glog.push_back(win);
          $display("[%0t] grant req%0d pktdata=%h pktvalid=%0b", $time, win, pktdata, pktvalid);
          for (int i = 0; i < NREQ; i++) begin
            if (i == win) wait_cnt[i] = 0;
            else if (req[i]) begin
              wait_cnt[i]++;
              check("fairness", 64'(wait_cnt[i] < NREQ), 64'd1);
            end
          end
        end
        for (int i = 0; i < NREQ; i++) if (!req[i]) wait_cnt[i] = 0;
      end
      prev_valid = pktvalid;
    end
  end

  // ---------------- ring node model ----------------
  bit node_auto = 1'b0, node_rand = 1'b0, pend = 1'b0;
  int ack_lat = 3, drain_lat = 5, ack_wait = 0, drain_wait = 0;

  always @(negedge clk) begin
    #1;
    if (rst) begin
      pend = 1'b0;
      drain_wait = 0;
    end else if (node_auto) begin
      if (drain_wait > 0) begin
        drain_wait--;
        if (drain_wait == 0) txready = 1'b1;
      end
      if (pend) begin
        ack_wait--;
        if (ack_wait == 0) begin
          pend = 1'b0;
          pktack = pktvalid;
          if (drain_lat > 0) begin
            txready = 1'b0;
            drain_wait = drain_lat;
          end
        end
      end else if (pktvalid !== pktack) begin
        if (node_rand) begin
          ack_lat = $urandom_range(3, 7);
          drain_lat = $urandom_range(0, 6);
        end
        pend = 1'b1;
        ack_wait = ack_lat;
      end else if (node_rand && drain_wait == 0 && $urandom_range(0, 99) < 5) begin
        txready = 1'b0;
        drain_wait = $urandom_range(1, 4);
      end
    end
  end

  // ---------------- random requesters ----------------
  bit rand_req = 1'b0;

  always @(negedge clk) begin
    #1;
    if (rand_req && !rst) begin
      for (int i = 0; i < NREQ; i++) begin
        if (req[i]) begin
          if (gnt[i] || $urandom_range(0, 99) < 2) req[i] = 1'b0;
        end else if ($urandom_range(0, 99) < 25) begin
          reqdata[i*WIDTH +: WIDTH] = 16'($urandom);
          req[i] = 1'b1;
        end
      end
    end
  end

  // ---------------- directed sequence helpers ----------------
  task automatic do_reset();
    rst = 1'b1; pktack = 1'b0; txready = 1'b1; pend = 1'b0; drain_wait = 0;
    @(negedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while (!(busy === 1'b0 && !pend && drain_wait == 0 && pktack === pktvalid) && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (n >= 500) timeout(name);
    @(negedge clk); #1;
  endtask

  int exp_order [5] = '{0, 1, 2, 3, 0};
  bit pv;
  int n0;

  initial begin
    // Reset values.
    repeat (3) @(negedge clk);
    check("rst_gnt", 64'(gnt), 64'd0);
    check("rst_pktvalid", 64'(pktvalid), 64'd0);
    check("rst_pktdata", 64'(pktdata), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_last", 64'(last), 64'd3);
    #1;
    rst = 1'b0;

    // Single request from requester 2.
    req = 4'b0100;
    reqdata[2*WIDTH +: WIDTH] = 16'h0A5C;
    @(negedge clk);
    check("t1_gnt", 64'(gnt), 64'h4);
    check("t1_pktdata", 64'(pktdata), 64'h8A5C);
    check("t1_pktvalid", 64'(pktvalid), 64'd1);
    check("t1_last", 64'(last), 64'd2);
    #1;
    req = '0;
    ack_lat = 3; drain_lat = 5; node_auto = 1'b1;
    wait_idle("t1_idle");

    // All four held: round-robin from requester 0.
    do_reset();
    for (int i = 0; i < NREQ; i++) reqdata[i*WIDTH +: WIDTH] = 16'(16'h1100 + i);
    glog.delete();
    req = 4'b1111;
    n0 = 0;
    while (glog.size() < 5 && n0 < 400) begin
      @(negedge clk);
      n0++;
    end
    #1;
    req = '0;
    if (glog.size() < 5) timeout("t2_grants");
    else for (int i = 0; i < 5; i++) check("t2_order", 64'(glog[i]), 64'(exp_order[i]));
    wait_idle("t2_idle");

    // Node buffer busy: no grant until txready returns.
    node_auto = 1'b0;
    txready = 1'b0;
    reqdata[1*WIDTH +: WIDTH] = 16'h1234;
    req = 4'b0010;
    pv = m_valid;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("t3_stall_gnt", 64'(gnt), 64'd0);
      check("t3_stall_pktvalid", 64'(pktvalid), 64'(pv));
    end
    #1;
    txready = 1'b1;
    @(negedge clk);
    check("t3_release_gnt", 64'(gnt), 64'h2);
    check("t3_release_pktdata", 64'(pktdata), 64'h9234);
    #1;
    req = '0;
    node_auto = 1'b1;
    wait_idle("t3_idle");

    // Reset while waiting for the ack.
    node_auto = 1'b0;
    reqdata[0 +: WIDTH] = 16'h0042;
    req = 4'b0001;
    n0 = 0;
    do begin
      @(negedge clk);
      n0++;
    end while (gnt == '0 && n0 < 10);
    check("t4_gnt", 64'(gnt), 64'h1);
    #1;
    req = '0;
    @(negedge clk);
    check("t4_busy_wait_ack", 64'(busy), 64'd1);
    #1;
    rst = 1'b1;
    @(negedge clk);
    check("t4_rst_pktvalid", 64'(pktvalid), 64'd0);
    check("t4_rst_busy", 64'(busy), 64'd0);
    check("t4_rst_gnt", 64'(gnt), 64'd0);
    check("t4_rst_last", 64'(last), 64'd3);
    #1;
    rst = 1'b0; pktack = 1'b0; txready = 1'b1; pend = 1'b0; drain_wait = 0;
    node_auto = 1'b1;
    reqdata[2*WIDTH +: WIDTH] = 16'h0123;
    req = 4'b0100;
    @(negedge clk);
    check("t4_after_gnt", 64'(gnt), 64'h4);
    check("t4_after_pktdata", 64'(pktdata), 64'h8123);
    check("t4_after_last", 64'(last), 64'd2);
    #1;
    req = '0;

    // One-cycle pulse on requester 3 while busy is never granted.
    gnt3_seen = 1'b0;
    reqdata[3*WIDTH +: WIDTH] = 16'h7777;
    req = 4'b1000;
    @(negedge clk); #1;
    req = '0;
    wait_idle("t5_idle");
    repeat (5) @(negedge clk);
    check("t5_pulse_no_grant", 64'(gnt3_seen), 64'd0);
    #1;

    // Randomized traffic.
    node_rand = 1'b1;
    rand_req = 1'b1;
    repeat (3000) @(negedge clk);
    #1;
    rand_req = 1'b0;
    req = '0;
    node_rand = 1'b0;
    ack_lat = 3; drain_lat = 5;
    wait_idle("rand_idle");

`ifdef RING_ARB_GRANT_COUNT_EN
    // Saturate requester 0's counter, then clear it.
    do_reset();
    ack_lat = 3; drain_lat = 0;
    reqdata[0 +: WIDTH] = 16'h0001;
    req = 4'b0001;
    n0 = 0;
    for (int c = 0; c < 6000 && n0 < 300; c++) begin
      @(negedge clk);
      if (gnt[0]) n0++;
    end
    #1;
    req = '0;
    if (n0 < 300) timeout("cnt_grants");
    wait_idle("cnt_idle");
    check("cnt_saturated", 64'(gntcount[7:0]), 64'd255);
    cntclr = 1'b1;
    @(negedge clk);
    check("cnt_cleared", 64'(gntcount[7:0]), 64'd0);
    #1;
    cntclr = 1'b0;
`endif

    @(negedge clk);
    check("toggle_per_grant", 64'(n_toggle), 64'(n_gntpulse));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  // Hard bound on total run time.
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish (dut=running expected=finished)");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail + 1);
    $fatal(1, "watchdog");
  end

endmodule
